// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port synchronous memory.
// One transaction at a time: IDLE -> ACCESS (WAIT+1 cycles) -> CAPTURE -> ACK.
module mem_arbiter #(
  parameter int WIDTH = 32,
  parameter int AW    = 16,
  parameter int WAIT  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m0_req,
  input  logic             m1_req,
  input  logic             m0_wen,
  input  logic             m1_wen,
  input  logic [AW-1:0]    m0_addr,
  input  logic [AW-1:0]    m1_addr,
  input  logic [WIDTH-1:0] m0_wdata,
  input  logic [WIDTH-1:0] m1_wdata,
  output logic             m0_ack,
  output logic             m1_ack,
  output logic [WIDTH-1:0] m0_rdata,
  output logic [WIDTH-1:0] m1_rdata,
  output logic             mem_cs,
  output logic             mem_wen,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [1:0]       grant
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, ACK} state_t;

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  state_t           state_reg, state_next;
  logic [1:0]       grant_reg, grant_next;
  logic             last_reg, last_next;   // 1 = port 1 was granted last
  logic [3:0]       cnt_reg, cnt_next;
  logic             wen_reg, wen_next;
  logic [AW-1:0]    addr_reg, addr_next;
  logic [WIDTH-1:0] wdata_reg, wdata_next;
  logic [WIDTH-1:0] rdata_reg, rdata_next;

  logic [1:0]       req_vec;
  logic [1:0]       wen_vec;
  logic [AW-1:0]    addr_vec  [2];
  logic [WIDTH-1:0] wdata_vec [2];
  logic [1:0]       ack_vec;
  logic             win;

  assign req_vec      = {m1_req, m0_req};
  assign wen_vec      = {m1_wen, m0_wen};
  assign addr_vec[0]  = m0_addr;
  assign addr_vec[1]  = m1_addr;
  assign wdata_vec[0] = m0_wdata;
  assign wdata_vec[1] = m1_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      grant_reg <= 2'b00;
      last_reg  <= 1'b1;
      cnt_reg   <= 4'd0;
      wen_reg   <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
      wen_reg   <= wen_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    wen_next   = wen_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    win        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req_vec) begin
          // On a tie the port that did not win last time goes first.
          win        = (req_vec == 2'b11) ? ~last_reg : req_vec[1];
          grant_next = win ? 2'b10 : 2'b01;
          last_next  = win;
          cnt_next   = 4'd0;
          wen_next   = wen_vec[win];
          addr_next  = addr_vec[win];
          wdata_next = wdata_vec[win];
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_reg == WAIT_CNT) begin
          state_next = CAPTURE;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      CAPTURE: begin
        if (!wen_reg) begin
          rdata_next = mem_rdata;
        end
        state_next = ACK;
      end
      ACK: begin
        grant_next = 2'b00;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ack
      assign ack_vec[gi] = (state_reg == ACK) && grant_reg[gi];
    end
  endgenerate

  assign m0_ack    = ack_vec[0];
  assign m1_ack    = ack_vec[1];
  assign m0_rdata  = rdata_reg;
  assign m1_rdata  = rdata_reg;
  assign mem_cs    = (state_reg == ACCESS);
  assign mem_wen   = mem_cs && wen_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign grant     = grant_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (WAIT = 0, 3, 5), each with its own
// synchronous memory model, checked cycle by cycle against a transaction-level model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic load_en;

  logic        m0_req [3], m1_req [3], m0_wen [3], m1_wen [3];
  logic [15:0] m0_addr [3], m1_addr [3];
  logic [31:0] m0_wdata [3], m1_wdata [3];
  logic        m0_ack_w [3], m1_ack_w [3];
  logic [31:0] m0_rdata_w [3], m1_rdata_w [3];
  logic        mem_cs_w [3], mem_wen_w [3];
  logic [15:0] mem_addr_w [3];
  logic [31:0] mem_wdata_w [3];
  logic [1:0]  grant_w [3];

  int checks = 0;
  int errors = 0;
  int last_g [3];
  logic [31:0] ref_mem [3][256];

  always #5 clk = ~clk;

  function automatic logic [31:0] pattern(input logic [7:0] a);
    return (a == 8'h10) ? 32'hDEADBEEF : {8'hA5, a, ~a, 8'h3C};
  endfunction

  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 3 : 5;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_inst
      logic [31:0] chip [0:255];
      logic [31:0] rd;

      always @(posedge clk) begin
        if (load_en) begin
          for (int i = 0; i < 256; i++) chip[i] <= pattern(8'(i));
        end else if (mem_cs_w[gi] && mem_wen_w[gi]) begin
          chip[mem_addr_w[gi][7:0]] <= mem_wdata_w[gi];
        end
        if (mem_cs_w[gi]) rd <= chip[mem_addr_w[gi][7:0]];
      end

      mem_arbiter #(
        .WIDTH(32),
        .AW(16),
        .WAIT((gi == 0) ? 0 : (gi == 1) ? 3 : 5)
      ) dut (
        .clk(clk),
        .reset(rst_n),
        .m0_req(m0_req[gi]),
        .m1_req(m1_req[gi]),
        .m0_wen(m0_wen[gi]),
        .m1_wen(m1_wen[gi]),
        .m0_addr(m0_addr[gi]),
        .m1_addr(m1_addr[gi]),
        .m0_wdata(m0_wdata[gi]),
        .m1_wdata(m1_wdata[gi]),
        .m0_ack(m0_ack_w[gi]),
        .m1_ack(m1_ack_w[gi]),
        .m0_rdata(m0_rdata_w[gi]),
        .m1_rdata(m1_rdata_w[gi]),
        .mem_cs(mem_cs_w[gi]),
        .mem_wen(mem_wen_w[gi]),
        .mem_addr(mem_addr_w[gi]),
        .mem_wdata(mem_wdata_w[gi]),
        .mem_rdata(rd),
        .grant(grant_w[gi])
      );
    end
  endgenerate

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s inst=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  // Expects to be called at a negedge while instance k is idle with its requests applied.
  // rel: 0 = keep requests, 1 = winner drops req at ack, 2 = both drop req at ack.
  task automatic check_txn(input int k, input bit drop0, input int rel);
    int w;
    bit win, ew;
    logic [15:0] ea;
    logic [31:0] ed, er;
    w = wait_of(k);
    if (m0_req[k] && m1_req[k]) win = (last_g[k] == 0);
    else win = m1_req[k];
    last_g[k] = win ? 1 : 0;
    ew = win ? m1_wen[k]   : m0_wen[k];
    ea = win ? m1_addr[k]  : m0_addr[k];
    ed = win ? m1_wdata[k] : m0_wdata[k];
    er = ref_mem[k][ea[7:0]];
    for (int c = 0; c <= w + 3; c++) begin
      @(negedge clk);
      chk("mem_cs", k, 64'(mem_cs_w[k]), 64'(c <= w));
      chk("mem_wen", k, 64'(mem_wen_w[k]), 64'((c <= w) && ew));
      if (c <= w) chk("mem_addr", k, 64'(mem_addr_w[k]), 64'(ea));
      if (c <= w && ew) chk("mem_wdata", k, 64'(mem_wdata_w[k]), 64'(ed));
      chk("grant", k, 64'(grant_w[k]), 64'((c <= w + 2) ? (win ? 2'b10 : 2'b01) : 2'b00));
      chk("ack_winner", k, 64'(win ? m1_ack_w[k] : m0_ack_w[k]), 64'(c == w + 2));
      chk("ack_loser", k, 64'(win ? m0_ack_w[k] : m1_ack_w[k]), 64'(0));
      if (c == w + 2 && !ew) chk("rdata", k, 64'(win ? m1_rdata_w[k] : m0_rdata_w[k]), 64'(er));
      if (c == 0) begin
        m0_wen[k] = 1'($urandom); m1_wen[k] = 1'($urandom);
        m0_addr[k] = 16'($urandom_range(0, 255)); m1_addr[k] = 16'($urandom_range(0, 255));
        m0_wdata[k] = $urandom; m1_wdata[k] = $urandom;
        if (drop0) m0_req[k] = 1'b0;
      end
      if (c == w + 2) begin
        if (rel == 2) begin
          m0_req[k] = 1'b0; m1_req[k] = 1'b0;
        end else if (rel == 1) begin
          if (win) m1_req[k] = 1'b0; else m0_req[k] = 1'b0;
        end
      end
    end
    if (ew) ref_mem[k][ea[7:0]] = ed;
  endtask

  initial begin
    int r;
    rst_n = 1'b0;
    load_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      m0_req[k] = 1'b0; m1_req[k] = 1'b0; m0_wen[k] = 1'b0; m1_wen[k] = 1'b0;
      m0_addr[k] = 16'h0; m1_addr[k] = 16'h0; m0_wdata[k] = 32'h0; m1_wdata[k] = 32'h0;
      last_g[k] = 1;
      for (int a = 0; a < 256; a++) ref_mem[k][a] = pattern(8'(a));
    end

    // Reset and idle
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_m0_ack", k, 64'(m0_ack_w[k]), 64'(0));
      chk("rst_m1_ack", k, 64'(m1_ack_w[k]), 64'(0));
      chk("rst_mem_cs", k, 64'(mem_cs_w[k]), 64'(0));
      chk("rst_mem_wen", k, 64'(mem_wen_w[k]), 64'(0));
      chk("rst_grant", k, 64'(grant_w[k]), 64'(0));
      chk("rst_mem_addr", k, 64'(mem_addr_w[k]), 64'(0));
      chk("rst_mem_wdata", k, 64'(mem_wdata_w[k]), 64'(0));
      chk("rst_rdata", k, 64'(m0_rdata_w[k]), 64'(0));
    end
    load_en = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        chk("idle_mem_cs", k, 64'(mem_cs_w[k]), 64'(0));
        chk("idle_grant", k, 64'(grant_w[k]), 64'(0));
        chk("idle_acks", k, 64'({m0_ack_w[k], m1_ack_w[k]}), 64'(0));
      end
    end

    // Single read, WAIT=0
    m0_req[0] = 1'b1; m0_wen[0] = 1'b0; m0_addr[0] = 16'h0010;
    check_txn(0, 1'b0, 1);

    // Write with wait states, WAIT=3, then readback by m0
    m1_req[1] = 1'b1; m1_wen[1] = 1'b1; m1_addr[1] = 16'h0004; m1_wdata[1] = 32'h12345678;
    check_txn(1, 1'b0, 1);
    m0_req[1] = 1'b1; m0_wen[1] = 1'b0; m0_addr[1] = 16'h0004;
    check_txn(1, 1'b0, 1);

    // Tie round-robin on a fresh instance
    m0_req[2] = 1'b1; m1_req[2] = 1'b1;
    m0_wen[2] = 1'b0; m1_wen[2] = 1'b0; m0_addr[2] = 16'h0010; m1_addr[2] = 16'h0011;
    for (int t = 0; t < 4; t++) check_txn(2, 1'b0, (t == 3) ? 2 : 0);

    // Abandoned request
    m0_req[0] = 1'b1; m0_wen[0] = 1'b0; m0_addr[0] = 16'h0005;
    check_txn(0, 1'b1, 1);
    @(negedge clk);
    chk("abandon_idle_cs", 0, 64'(mem_cs_w[0]), 64'(0));
    chk("abandon_idle_grant", 0, 64'(grant_w[0]), 64'(0));

    // Reset in the middle of an access, WAIT=5
    m0_req[2] = 1'b1; m0_wen[2] = 1'b0; m0_addr[2] = 16'h0030;
    @(negedge clk);
    chk("mid_cs_before", 2, 64'(mem_cs_w[2]), 64'(1));
    m1_req[2] = 1'b1; m1_wen[2] = 1'b0; m1_addr[2] = 16'h0031;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_cs_async", 2, 64'(mem_cs_w[2]), 64'(0));
    chk("mid_grant_async", 2, 64'(grant_w[2]), 64'(0));
    for (int k = 0; k < 3; k++) last_g[k] = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mid_no_ack", 2, 64'({m0_ack_w[2], m1_ack_w[2]}), 64'(0));
    end
    m0_req[2] = 1'b0;
    rst_n = 1'b1;
    check_txn(2, 1'b0, 1);
    m0_req[2] = 1'b1; m1_req[2] = 1'b1;
    check_txn(2, 1'b0, 2);

    // Randomized traffic across all instances
    for (int n = 0; n < 60; n++) begin
      int k;
      k = $urandom_range(0, 2);
      r = $urandom_range(1, 3);
      m0_req[k] = r[0]; m1_req[k] = r[1];
      m0_wen[k] = 1'($urandom); m1_wen[k] = 1'($urandom);
      m0_addr[k] = 16'($urandom_range(0, 31)); m1_addr[k] = 16'($urandom_range(0, 31));
      m0_wdata[k] = $urandom; m1_wdata[k] = $urandom;
      check_txn(k, 1'b0, 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the computer's single-port synchronous memory between the CPU bus master (port 0) and a debug/monitor master (port 1). It accepts one request at a time over a req/ack handshake and sequences the memory chip-select, address and write strobe with a configurable number of wait states. It registers read data back to the winning requester. Ties are resolved round-robin, so neither master starves.

## Interface
- WIDTH, 32, data width of both ports and memory
- AW, 16, address width
- WAIT, 0, extra memory wait cycles per access (0..15)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- m0_req, m1_req  in  1  access request, held until ack
- m0_wen, m1_wen  in  1  1 = write, 0 = read; sampled with req
- m0_addr, m1_addr  in  AW  access address
- m0_wdata, m1_wdata  in  WIDTH  write data
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- m0_rdata, m1_rdata  out  WIDTH  read data, valid while own ack is high
- mem_cs  out  1  memory chip select
- mem_wen  out  1  memory write enable, only with mem_cs
- mem_addr  out  AW  memory address
- mem_wdata  out  WIDTH  memory write data
- mem_rdata  in  WIDTH  memory read data, valid the cycle after an addressed cycle
- grant  out  2  one-hot owner of current transaction, 00 when idle

## Operation
- States: IDLE, ACCESS, CAPTURE, ACK.
- IDLE: if any req is high, select a winner and latch its wen/addr/wdata into internal registers. Set grant, clear wait counter, go to ACCESS. Otherwise stay.
- Selection rules:
  - Only one requester: that requester wins.
  - Both requesting: the port not granted last wins.
  - The last-grant bit updates on every selection.
- ACCESS: mem_cs=1 and mem_addr/mem_wdata/mem_wen come from the latched registers.
  - Lasts WAIT+1 cycles; a 4-bit counter increments each cycle, exit when counter==WAIT.
  - Writes keep mem_wen high for all ACCESS cycles.
- CAPTURE: mem_cs=0 and mem_wen=0. On the edge leaving CAPTURE, mem_rdata is latched into rdata_q for reads. For writes, rdata_q is unchanged.
- ACK: the granted port's ack=1 for exactly one cycle and its rdata=rdata_q. The other port's ack=0. Next state is IDLE, with grant cleared on entering IDLE.
- Requester dropping req mid-transaction: the transaction still completes and ack still pulses.
- req still high in the cycle after ACK: treated as a new request in IDLE, with arbitration applied again.
- Non-granted rdata outputs hold rdata_q; their value is don't-care and not checked.
- mem_addr/mem_wdata hold the latched values outside ACCESS; only mem_cs/mem_wen qualify them.

## Timing
- Reset (reset=0, asynchronous) forces:
  - state IDLE, all ack=0, mem_cs=0, mem_wen=0, grant=00;
  - mem_addr, mem_wdata and rdata_q to 0;
  - last-grant = port 1, so port 0 wins the first tie.
- Reset mid-transaction aborts it with no ack. Release is synchronous to the next clk edge.
- Latency: req is sampled high in IDLE at edge E0.
  - ACCESS occupies cycles E0..E0+WAIT.
  - CAPTURE occupies E0+WAIT+1.
  - ack is high during cycle E0+WAIT+2.
  - With WAIT=0, ack is high in the third cycle after the sampling edge.
- Throughput: one transaction per WAIT+4 cycles (including the IDLE cycle).
- Simultaneous req on both ports in IDLE is resolved in the same cycle; the loser waits for the next IDLE.
- Inputs m*_addr/wdata/wen may change after the sampling edge with no effect.

## Test plan
- Reset/idle: hold reset=0, then release with no req.
  - Required: all outputs 0, grant=00, no mem_cs for 20 cycles.
- Single read, WAIT=0: m0 reads addr 0x0010 with memory model returning 0xDEADBEEF.
  - Required: mem_cs high for 1 cycle with mem_addr=0x0010 and mem_wen=0.
  - Required: m0_ack high 2 cycles after the sampling edge, m0_rdata=0xDEADBEEF, m1_ack stays 0.
- Write with wait states, WAIT=3: m1 writes 0x12345678 to 0x0004.
  - Required: mem_cs and mem_wen high for exactly 4 cycles with that address/data.
  - Required: m1_ack pulses once, 5 cycles after the sampling edge; a memory readback by m0 returns 0x12345678.
- Tie round-robin: both ports hold req continuously for 4 transactions.
  - Required: grant sequence 01,10,01,10 and acks alternate m0,m1,m0,m1.
- Abandoned request: m0 drops req in the first ACCESS cycle.
  - Required: the transaction still completes, m0_ack still pulses once, then the arbiter returns to IDLE with grant=00.
- Reset mid-operation: assert reset=0 during ACCESS with WAIT=5.
  - Required: mem_cs falls immediately (asynchronously) and no ack is issued.
  - Required: after release, a pending m1 req is served normally and port 0 wins the next tie.
